// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: synchronised input, mid-bit sampling, parity/framing
// error flags, break detection and an armed idle-block timeout pulse.
module uart_rx_cfg #(
    parameter int CLKS_PER_BIT = 9,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int BLK_TIMEOUT  = 20,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 rx_bsy,
    output logic                 data_valid,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 block_timeout
);
    localparam int CNT_MAX = (CLKS_PER_BIT > BLK_TIMEOUT) ? CLKS_PER_BIT : BLK_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int BW      = $clog2(DATA_BITS + 1);

    localparam logic [CW-1:0] CNT_MID   = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] IDLE_LAST = CW'(BLK_TIMEOUT - 1);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP, BRK} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_p0;
    logic                   rx_s;
    logic                   rx_s_p1;
    logic                   fall;
    logic                   stop_low;
    logic [CW-1:0]          cnt;
    logic [CW-1:0]          idle_cnt;
    logic [BW-1:0]          bit_idx;
    logic [DATA_BITS-1:0]   shreg;
    logic                   par_bit;
    logic                   ferr;
    logic                   all_zero;
    logic                   armed;

    function automatic logic parity_bad(input logic [DATA_BITS-1:0] d, input logic p);
        logic x;
        x = (^d) ^ p;
        return (PARITY == 1) ? ~x : x;
    endfunction

    // Synchroniser stage: flops preset to idle-high so reset release never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= '1;
            rx_s_p1 <= 1'b1;
        end else begin
            sync_p0 <= {sync_p0[SYNC_STAGES-2:0], rx};
            rx_s_p1 <= rx_s;
        end
    end

    assign rx_s     = sync_p0[SYNC_STAGES-1];
    assign fall     = rx_s_p1 & ~rx_s;
    assign stop_low = ferr | ~rx_s;

    // Frame stage: sampling FSM, output pulses and block timeout
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            idle_cnt      <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
            par_bit       <= 1'b0;
            ferr          <= 1'b0;
            all_zero      <= 1'b1;
            armed         <= 1'b0;
            rx_bsy        <= 1'b0;
            data_valid    <= 1'b0;
            data_out      <= '0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            break_det     <= 1'b0;
            block_timeout <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            parity_err    <= 1'b0;
            frame_err     <= 1'b0;
            break_det     <= 1'b0;
            block_timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (fall) begin
                        state    <= START;
                        cnt      <= '0;
                        rx_bsy   <= 1'b1;
                        idle_cnt <= '0;
                    end else if (armed && rx_s) begin
                        if (idle_cnt == IDLE_LAST) begin
                            block_timeout <= 1'b1;
                            armed         <= 1'b0;
                            idle_cnt      <= '0;
                        end else begin
                            idle_cnt <= idle_cnt + CW'(1);
                        end
                    end
                end
                START: begin
                    if (cnt == CNT_MID) begin
                        if (rx_s) begin
                            state  <= IDLE;
                            rx_bsy <= 1'b0;
                        end else begin
                            state    <= DATA;
                            cnt      <= '0;
                            bit_idx  <= '0;
                            all_zero <= 1'b1;
                            ferr     <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        shreg    <= {rx_s, shreg[DATA_BITS-1:1]};
                        all_zero <= all_zero & ~rx_s;
                        if (bit_idx == DATA_LAST) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? PAR : STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                PAR: begin
                    if (cnt == CNT_LAST) begin
                        cnt      <= '0;
                        par_bit  <= rx_s;
                        all_zero <= all_zero & ~rx_s;
                        bit_idx  <= '0;
                        state    <= STOP;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt == CNT_LAST) begin
                        cnt <= '0;
                        if (bit_idx == STOP_LAST) begin
                            // Break takes precedence over a normal (possibly errored) completion
                            if (all_zero && stop_low) begin
                                break_det <= 1'b1;
                                state     <= BRK;
                            end else begin
                                data_valid <= 1'b1;
                                data_out   <= shreg;
                                parity_err <= (PARITY != 0) && parity_bad(shreg, par_bit);
                                frame_err  <= stop_low;
                                rx_bsy     <= 1'b0;
                                armed      <= 1'b1;
                                idle_cnt   <= '0;
                                state      <= IDLE;
                            end
                        end else begin
                            ferr    <= stop_low;
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                BRK: begin
                    if (rx_s) begin
                        state  <= IDLE;
                        rx_bsy <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    rx_bsy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: an 8N1 and an 8E1 instance driven by serial frames,
// checked with a vector table, hand sequences and a randomized frame model.
module tb_uart_rx_cfg;
    localparam int CPB = 9;
    localparam int BLK = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx_n = 1'b1;
    logic rx_e = 1'b1;
    logic bsy_n, dv_n, perr_n, ferr_n, brk_n, bto_n;
    logic bsy_e, dv_e, perr_e, ferr_e, brk_e, bto_e;
    logic [7:0] dout_n, dout_e;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .BLK_TIMEOUT(BLK), .SYNC_STAGES(2)) u_n (
        .clk(clk), .rst(rst), .rx(rx_n), .rx_bsy(bsy_n), .data_valid(dv_n),
        .data_out(dout_n), .parity_err(perr_n), .frame_err(ferr_n),
        .break_det(brk_n), .block_timeout(bto_n));

    uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                  .BLK_TIMEOUT(BLK), .SYNC_STAGES(2)) u_e (
        .clk(clk), .rst(rst), .rx(rx_e), .rx_bsy(bsy_e), .data_valid(dv_e),
        .data_out(dout_e), .parity_err(perr_e), .frame_err(ferr_e),
        .break_det(brk_e), .block_timeout(bto_e));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor: index 0 = 8N1 instance, index 1 = 8E1 instance
    int dv_cnt[2] = '{0, 0};
    int brk_cnt[2] = '{0, 0};
    int bto_cnt[2] = '{0, 0};
    int bsy_cnt[2] = '{0, 0};
    int dv_cyc[2] = '{0, 0};
    int bto_cyc[2] = '{0, 0};
    logic [7:0] last_data[2];
    logic last_perr[2];
    logic last_ferr[2];
    int stray = 0;

    always @(negedge clk) begin
        if (dv_n) begin
            dv_cnt[0] <= dv_cnt[0] + 1; dv_cyc[0] <= cyc;
            last_data[0] <= dout_n; last_perr[0] <= perr_n; last_ferr[0] <= ferr_n;
        end
        if (dv_e) begin
            dv_cnt[1] <= dv_cnt[1] + 1; dv_cyc[1] <= cyc;
            last_data[1] <= dout_e; last_perr[1] <= perr_e; last_ferr[1] <= ferr_e;
        end
        if (brk_n) brk_cnt[0] <= brk_cnt[0] + 1;
        if (brk_e) brk_cnt[1] <= brk_cnt[1] + 1;
        if (bto_n) begin bto_cnt[0] <= bto_cnt[0] + 1; bto_cyc[0] <= cyc; end
        if (bto_e) begin bto_cnt[1] <= bto_cnt[1] + 1; bto_cyc[1] <= cyc; end
        if (bsy_n) bsy_cnt[0] <= bsy_cnt[0] + 1;
        if (bsy_e) bsy_cnt[1] <= bsy_cnt[1] + 1;
        if (((perr_n | ferr_n) & ~dv_n) | ((perr_e | ferr_e) & ~dv_e)) stray <= stray + 1;
    end

    int checks = 0;
    int passes = 0;
    int start_cyc[2] = '{0, 0};

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic check_near(input string name, input int act, input int exp);
        checks++;
        if (act >= exp - 1 && act <= exp + 1) passes++;
        else $display("FAIL %s: got %0d, expected %0d +/-1", name, act, exp);
    endtask

    task automatic drive(input int dut, input logic v);
        if (dut == 0) rx_n = v;
        else rx_e = v;
    endtask

    task automatic hold(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Start bit, 8 data bits LSB first, parity bit on the 8E1 instance, stop bit, 3 idle bits
    task automatic send_frame(input int dut, input logic [7:0] d, input logic p, input logic s);
        start_cyc[dut] = cyc;
        drive(dut, 1'b0); hold(CPB);
        for (int i = 0; i < 8; i++) begin
            drive(dut, d[i]); hold(CPB);
        end
        if (dut == 1) begin
            drive(dut, p); hold(CPB);
        end
        drive(dut, s); hold(CPB);
        drive(dut, 1'b1); hold(3 * CPB);
    endtask

    typedef struct {
        int         dut;
        logic [7:0] data;
        logic       pbit;
        logic       stop;
        logic       exp_dv;
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_brk;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int dv0, br0, bt0, bs0, lat, ones;
        logic [7:0] d;
        logic p, s, e_brk, e_perr, e_ferr;

        vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{1, 8'h03, 1'b1, 1'b1, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{1, 8'h03, 1'b0, 1'b1, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0};
        vecs[3] = '{0, 8'h55, 1'b0, 1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{1, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{1, 8'h80, 1'b1, 1'b0, 1'b1, 8'h80, 1'b0, 1'b1, 1'b0};
        vecs[6] = '{0, 8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
        vecs[7] = '{1, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0};

        hold(5);
        check("reset_outputs_8n1", int'({bsy_n, dv_n, perr_n, ferr_n, brk_n, bto_n, dout_n}), 0);
        check("reset_outputs_8e1", int'({bsy_e, dv_e, perr_e, ferr_e, brk_e, bto_e, dout_e}), 0);
        rst = 1'b0;
        hold(3 * BLK);
        check("no_timeout_after_reset_8n1", bto_cnt[0], 0);
        check("no_timeout_after_reset_8e1", bto_cnt[1], 0);

        for (int v = 0; v < 8; v++) begin
            dv0 = dv_cnt[vecs[v].dut];
            br0 = brk_cnt[vecs[v].dut];
            send_frame(vecs[v].dut, vecs[v].data, vecs[v].pbit, vecs[v].stop);
            check($sformatf("vec%0d_dv_count", v), dv_cnt[vecs[v].dut] - dv0, int'(vecs[v].exp_dv));
            check($sformatf("vec%0d_brk_count", v), brk_cnt[vecs[v].dut] - br0, int'(vecs[v].exp_brk));
            check($sformatf("vec%0d_bsy_after", v), int'(vecs[v].dut == 0 ? bsy_n : bsy_e), 0);
            if (vecs[v].exp_dv) begin
                check($sformatf("vec%0d_data", v), int'(last_data[vecs[v].dut]), int'(vecs[v].exp_data));
                check($sformatf("vec%0d_parity_err", v), int'(last_perr[vecs[v].dut]), int'(vecs[v].exp_perr));
                check($sformatf("vec%0d_frame_err", v), int'(last_ferr[vecs[v].dut]), int'(vecs[v].exp_ferr));
                lat = dv_cyc[vecs[v].dut] - start_cyc[vecs[v].dut];
                check_near($sformatf("vec%0d_latency", v), lat,
                           CPB / 2 + (8 + vecs[v].dut + 1) * CPB + 2 + 2);
            end
        end

        // Short low glitch on an idle line: busy briefly, nothing reported
        dv0 = dv_cnt[0]; bs0 = bsy_cnt[0];
        rx_n = 1'b0; hold(3);
        rx_n = 1'b1; hold(3 * CPB);
        check("glitch_bsy_seen", int'(bsy_cnt[0] != bs0), 1);
        check("glitch_bsy_after", int'(bsy_n), 0);
        check("glitch_no_dv", dv_cnt[0] - dv0, 0);

        // Line held low for 15 bit times: one break, then a normal frame
        dv0 = dv_cnt[0]; br0 = brk_cnt[0];
        rx_n = 1'b0; hold(12 * CPB);
        check("break_bsy_during", int'(bsy_n), 1);
        hold(3 * CPB);
        rx_n = 1'b1; hold(2 * CPB);
        check("break_pulse_count", brk_cnt[0] - br0, 1);
        check("break_no_dv", dv_cnt[0] - dv0, 0);
        check("break_bsy_released", int'(bsy_n), 0);
        send_frame(0, 8'h41, 1'b0, 1'b1);
        check("after_break_dv", dv_cnt[0] - dv0, 1);
        check("after_break_data", int'(last_data[0]), 'h41);

        // Block timeout after a completed frame
        bt0 = bto_cnt[0];
        send_frame(0, 8'h10, 1'b0, 1'b1);
        hold(2 * BLK);
        check("timeout_data", int'(last_data[0]), 'h10);
        check("timeout_pulse_count", bto_cnt[0] - bt0, 1);
        check("timeout_delay", bto_cyc[0] - dv_cyc[0], BLK);

        // Randomized frames on the parity instance against the frame-rule model
        for (int k = 0; k < 30; k++) begin
            d = 8'($urandom);
            p = 1'($urandom);
            s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                d = 8'h00; p = 1'b0; s = 1'b0;
            end
            ones   = $countones(d) + int'(p);
            e_brk  = (d == 8'h00) && !p && !s;
            e_perr = (ones % 2) != 0;
            e_ferr = !s;
            dv0 = dv_cnt[1]; br0 = brk_cnt[1];
            send_frame(1, d, p, s);
            hold($urandom_range(0, 2) * CPB);
            check($sformatf("rand%0d_dv", k), dv_cnt[1] - dv0, int'(!e_brk));
            check($sformatf("rand%0d_brk", k), brk_cnt[1] - br0, int'(e_brk));
            if (!e_brk) begin
                check($sformatf("rand%0d_data", k), int'(last_data[1]), int'(d));
                check($sformatf("rand%0d_perr", k), int'(last_perr[1]), int'(e_perr));
                check($sformatf("rand%0d_ferr", k), int'(last_ferr[1]), int'(e_ferr));
            end
        end

        // Reset in the middle of a frame aborts it silently
        dv0 = dv_cnt[0];
        rx_n = 1'b0; hold(CPB);
        rx_n = 1'b0; hold(CPB);
        rx_n = 1'b1; hold(2 * CPB);
        rst = 1'b1; hold(2);
        check("rst_mid_outputs", int'({bsy_n, dv_n, perr_n, ferr_n, brk_n, bto_n}), 0);
        check("rst_mid_data_out", int'(dout_n), 0);
        rst = 1'b0;
        rx_n = 1'b1; hold(15 * CPB);
        check("rst_mid_no_dv", dv_cnt[0] - dv0, 0);
        check("rst_mid_bsy_after", int'(bsy_n), 0);

        check("no_stray_error_pulses", stray, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
